adder_arbiter: RTL



---
 rtl/adder_arbiter_pkg.sv | 16 +
 rtl/ripple_carry_adder.sv | 25 ++
 rtl/adder_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter: FSM state encodings
// and the requester-ID width helper.
package adder_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // A single requester still needs a one-bit ID field.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder; purely combinational, so o_ready is tied high.
module ripple_carry_adder #(
   parameter int NUM_BITS = 32
) (
   input  logic [NUM_BITS-1:0] i_a,
   input  logic [NUM_BITS-1:0] i_b,
   input  logic                i_cin,
   output logic [NUM_BITS-1:0] o_sum,
   output logic                o_cout,
   output logic                o_ready
);

   logic [NUM_BITS:0] w_carry;

   assign w_carry[0] = i_cin;

   for (genvar i = 0; i < NUM_BITS; i++) begin : g_fa
      assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
      assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_cout  = w_carry[NUM_BITS];
   assign o_ready = 1'b1;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one ripple_carry_adder among NUM_REQ requesters.
// Operands and results are registered so the carry chain has a full cycle.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int NUM_BITS = 32,
   parameter int NUM_REQ  = 4,
   parameter int ID_W     = id_width(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*NUM_BITS-1:0] req_a,
   input  logic [NUM_REQ*NUM_BITS-1:0] req_b,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [NUM_BITS-1:0]         rsp_sum,
   output logic                        rsp_cout,
   output logic [ID_W-1:0]             rsp_id,
   output logic                        busy
);

   state_t              r_state;
   state_t              w_next_state;
   logic [ID_W-1:0]     r_last_grant;
   logic [ID_W-1:0]     r_id;
   logic [ID_W-1:0]     w_idx;
   logic [ID_W-1:0]     w_grant_idx;
   logic                w_found;
   logic                w_accept;
   logic                w_handshake;
   logic [NUM_BITS-1:0] r_a;
   logic [NUM_BITS-1:0] r_b;
   logic [NUM_BITS-1:0] r_sum;
   logic [NUM_BITS-1:0] w_sum;
   logic [NUM_BITS-1:0] w_sel_a;
   logic [NUM_BITS-1:0] w_sel_b;
   logic                r_cout;
   logic                w_cout;
   logic                r_rsp_valid;
   logic                r_busy;
   logic                w_unused_ready;

   // Round-robin search: first valid requester after the last granted one.
   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = '0;
      w_idx       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx       = ID_W'((int'(r_last_grant) + i) % NUM_REQ);
         w_grant_idx = (!w_found && req_valid[w_idx]) ? w_idx : w_grant_idx;
         w_found     = w_found | req_valid[w_idx];
      end
   end

   // Operand slice of the winning requester.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sel_a = (w_grant_idx == ID_W'(i)) ? req_a[i*NUM_BITS +: NUM_BITS] : w_sel_a;
         w_sel_b = (w_grant_idx == ID_W'(i)) ? req_b[i*NUM_BITS +: NUM_BITS] : w_sel_b;
      end
   end

   // Grant is only offered when idle or when the pending result drains this cycle.
   always_comb begin
      w_accept    = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
      w_handshake = w_accept && w_found;
      req_ready   = '0;
      if (w_handshake) begin
         req_ready[w_grant_idx] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: w_next_state = w_handshake ? ST_CALC : ST_IDLE;
         ST_CALC: w_next_state = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               w_next_state = w_handshake ? ST_CALC : ST_IDLE;
            end else begin
               w_next_state = ST_RESP;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Operand, ID and round-robin pointer capture on the request handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a          <= '0;
         r_b          <= '0;
         r_id         <= '0;
         r_last_grant <= ID_W'(NUM_REQ - 1);
      end else if (w_handshake) begin
         r_a          <= w_sel_a;
         r_b          <= w_sel_b;
         r_id         <= w_grant_idx;
         r_last_grant <= w_grant_idx;
      end
   end

   // Result capture and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rsp_valid <= (w_next_state == ST_RESP);
         r_busy      <= (w_next_state != ST_IDLE);
         if (r_state == ST_CALC) begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
         end
      end
   end

   ripple_carry_adder #(
      .NUM_BITS (NUM_BITS)
   ) u_adder (
      .i_a     (r_a),
      .i_b     (r_b),
      .i_cin   (1'b0),
      .o_sum   (w_sum),
      .o_cout  (w_cout),
      .o_ready (w_unused_ready)
   );

   assign rsp_valid = r_rsp_valid;
   assign rsp_sum   = r_sum;
   assign rsp_cout  = r_cout;
   assign rsp_id    = r_id;
   assign busy      = r_busy;

endmodule
